// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst write arbiter in front of the circular FIFO write port
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    ack,
    output logic [NREQ-1:0]    grant,
    input  logic               fifo_full,
    output logic               fifo_wr_en,
    output logic [DW-1:0]      fifo_din,
    output logic               busy,
    output logic [3:0]         beat_cnt
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [3:0] LAST_BEAT = 4'(BURST - 1);

    typedef enum logic {IDLE, XFER} state_t;

    state_t          state, state_nxt;
    logic [NREQ-1:0] grant_nxt;
    logic [3:0]      cnt_nxt;
    logic [IW-1:0]   last, last_nxt;
    logic [IW-1:0]   gidx;
    logic [IW-1:0]   sel_idx;
    logic            sel_found;

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) gidx = IW'(i);
        end
    end

    // Search starts just above the last served requester so it ends up lowest priority.
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!sel_found && req[(int'(last) + k) % NREQ]) begin
                sel_found = 1'b1;
                sel_idx   = IW'((int'(last) + k) % NREQ);
            end
        end
    end

    assign busy       = (state == XFER);
    assign fifo_wr_en = busy & req[gidx] & ~fifo_full;
    assign fifo_din   = busy ? wdata[int'(gidx)*DW +: DW] : '0;
    assign ack        = fifo_wr_en ? grant : '0;

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        cnt_nxt   = beat_cnt;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    state_nxt = XFER;
                    grant_nxt = NREQ'(1) << sel_idx;
                    cnt_nxt   = '0;
                end
            end
            XFER: begin
                if (!req[gidx] || (fifo_wr_en && beat_cnt == LAST_BEAT)) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    cnt_nxt   = '0;
                    last_nxt  = gidx;
                end else if (fifo_wr_en) begin
                    cnt_nxt = beat_cnt + 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            grant    <= '0;
            beat_cnt <= '0;
            last     <= IW'(NREQ - 1);
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            beat_cnt <= cnt_nxt;
            last     <= last_nxt;
        end
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares the write port of the 8-bit circular FIFO among several producers. Each requester presents data with a level request and is granted the FIFO for a bounded burst of beats. The arbiter drives the FIFO's write enable and data and obeys its full flag. It sits directly in front of the FIFO's `wr_en`/`buf_in` inputs; the read side is untouched.

## Interface

Parameters:
- `NREQ`, 4: number of requesters, legal range 2..8.
- `DW`, 8: data width; matches the FIFO word.
- `BURST`, 4: maximum beats per grant, legal range 1..15.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset. The port keeps the codebase name `rst`; polarity is low-true.
- `req`  in  NREQ  per-requester request. Held high while that requester has data.
- `wdata`  in  NREQ*DW  flattened requester data. Requester i occupies bits `[i*DW +: DW]`.
- `ack`  out  NREQ  one-hot. Beat accepted from requester i this cycle.
- `grant`  out  NREQ  one-hot registered grant. All zero when idle.
- `fifo_full`  in  1  FIFO full flag (`buf_full`).
- `fifo_wr_en`  out  1  FIFO write enable.
- `fifo_din`  out  DW  FIFO write data.
- `busy`  out  1  high in XFER state.
- `beat_cnt`  out  4  beats written in the current grant.

## Operation

- FSM has two states, IDLE and XFER.
- **IDLE:**
  - If any `req` bit is set, select the first set bit searching upward from `last+1`, wrapping modulo NREQ.
  - Register the selection into `grant`, clear `beat_cnt` and go to XFER.
  - If no bit is set, stay in IDLE with `grant`=0.
- **XFER** (granted index g):
  - `fifo_wr_en` = `req[g]` & !`fifo_full` (combinational).
  - `fifo_din` = `wdata[g*DW +: DW]`, always driven from the granted slice.
  - `ack[g]` = `fifo_wr_en`; all other `ack` bits are 0.
  - On each write, `beat_cnt` increments.
  - Exit to IDLE when a write occurs with `beat_cnt`==BURST-1 (burst complete).
  - Exit to IDLE when `req[g]`==0 (requester done); no write occurs in that cycle.
  - On either exit, `last`<=g, and `grant` and `beat_cnt` clear at the same edge.
  - `fifo_full`=1 with `req[g]`=1: stall. Stay in XFER, no write, no count, grant held.
- **Handshake:**
  - A requester holds `wdata` stable until it sees `ack`.
  - It may present new data on the cycle after `ack`.
  - It may drop `req` at any time. A dropped request forfeits the rest of its burst.
- **Fairness:** after g is served, g has lowest priority at the next arbitration. Any continuously requesting requester is granted within NREQ-1 intervening grants.
- **Reset** (asynchronous, any state, including mid-burst):
  - State returns to IDLE.
  - `grant`, `ack`, `fifo_wr_en`, `busy` and `beat_cnt` go to 0.
  - `fifo_din` goes to 0, forced while IDLE.
  - `last` goes to NREQ-1, so requester 0 has top priority after reset.
  - A beat in flight at reset is not written.
- `beat_cnt` is 4 bits wide and never exceeds BURST-1 while in XFER.

## Timing

- Request-to-first-write:
  - `req` rises in cycle 0 while IDLE.
  - `grant` is valid in cycle 1.
  - The first `ack`/`fifo_wr_en` occurs in cycle 1 if not full.
- Throughput: one beat per cycle within a burst.
- Re-arbitration bubble: exactly one IDLE cycle between consecutive grants. Peak efficiency is BURST/(BURST+1).
- `fifo_full` must be the same-cycle flag. The FIFO updates full on the edge of the write, so a write with `fifo_full`=0 is always accepted.
- `ack`, `fifo_wr_en` and `fifo_din` are combinational from registered grant, `req`, `wdata` and `fifo_full`. `grant`, `busy` and `beat_cnt` are registered.

## Test plan

- **Single burst:** `req`=0001 continuously, BURST=4, FIFO empty.
  - `grant`=0001 in cycles 1–4 with 4 acks.
  - `wdata` 0xA0..0xA3 is written in order.
  - IDLE in cycle 5; re-grant to requester 0 in cycle 6.
- **Round robin:** `req`=1111 held.
  - Grant order is 0,1,2,3,0.
  - Each grant lasts 4 beats, separated by 1 bubble.
  - No grant overlap; `ack` is one-hot.
- **Full stall:** `fifo_full` raised after beat 2 of 4 for 3 cycles.
  - No `fifo_wr_en` during the stall; `beat_cnt` holds at 2.
  - Grant is held.
  - Beats 3 and 4 are written after `fifo_full` falls.
- **Early drop:** requester 2 drops `req` after 2 beats, with `req`=0101.
  - Exit after 2 writes.
  - Next grant goes to requester 0, not 2. A pending `req`=0001 alone receives the grant after the bubble.
- **Mid-burst reset:** `rst` pulled low during beat 3.
  - All outputs are 0 immediately, with no clock edge required.
  - After release with `req`=1010, the first grant goes to requester 1.
- **BURST=1, NREQ=2:** both requesting.
  - Alternating single-beat grants 0,1,0,1 with a bubble between each.
  - Exactly one write per 2 cycles.
